gpu_hw_regs_shadowed: RTL
=========================

// Module: gpu_hw_regs_shadowed
// PURPOSE
//  Parametrised GPU hardware control register bank with host read-back and double buffering.
//  Host writes land in a shadow bank. The shadow bank is copied atomically into the active
//  bank at a frame boundary, so the video pipeline never sees a half-updated register set.
//  Sits between the host bus decoder and the video timing/pixel pipeline.
// PARAMETERS
//  ADDR_W     20      host address width
//  REG_AW     8       register index width; NUM_REGS = 2**REG_AW
//  DW         8       register data width
//  BASE_ADDR  20'h0   bank base; only bits [ADDR_W-1:REG_AW] are compared
//  RST_COUNT  32      regs 0..RST_COUNT-1 reset to (i+1) mod 2**DW; remaining regs reset to 0
//  IMMEDIATE  0       1 = active bank tracks shadow on every write (no frame sync)
// PORTS
//  clk          in   1                 clock
//  rst          in   1                 synchronous, active-high reset
//  we           in   1                 host write strobe
//  re           in   1                 host read strobe
//  addr_in      in   ADDR_W            host address
//  data_in      in   DW                host write data
//  rd_data      out  DW                read-back data (shadow bank)
//  rd_valid     out  1                 rd_data valid pulse
//  vsync_pulse  in   1                 1-cycle frame-boundary strobe
//  force_commit in   1                 commit on this cycle regardless of vsync_pulse
//  pending      out  1                 shadow differs from active (uncommitted writes)
//  commit_ack   out  1                 1-cycle pulse, cycle after a commit
//  active_regs  out  [0:NUM_REGS-1][DW] active bank, consumed by the video pipeline
// BEHAVIOUR
//  - hit = addr_in[ADDR_W-1:REG_AW] == BASE_ADDR[ADDR_W-1:REG_AW]; idx = addr_in[REG_AW-1:0].
//  - Reset: shadow and active banks both take the RST_COUNT pattern.
//    Reset clears rd_data, rd_valid, pending and commit_ack to 0.
//    Reset overrides any in-flight write, read or commit.
//  - Write: we&&hit -> shadow[idx] <= data_in at the next edge. A miss is ignored.
//  - Read: re&&hit -> at the next edge rd_data <= shadow[idx] and rd_valid <= 1 (latency 1).
//    A miss leaves rd_valid 0 and rd_data held. rd_valid is 0 whenever the previous cycle had no read hit.
//  - Read and write to the same idx in one cycle: the read returns the pre-write value.
//  - State machine, IMMEDIATE=0:
//    - CLEAN: a write hit -> DIRTY.
//    - DIRTY: (vsync_pulse||force_commit) -> COMMIT.
//    - COMMIT: a single-cycle copy of all NUM_REGS shadow->active.
//      If no write hit lands in the COMMIT cycle -> CLEAN; otherwise -> DIRTY.
//    - commit_ack is asserted in the cycle after COMMIT.
//    - pending = 1 in DIRTY and COMMIT, 0 in CLEAN.
//  - A write in the same cycle as the commit trigger (DIRTY->COMMIT transition) is included in the copy.
//    A write during COMMIT stays in shadow only, and pending stays 1.
//  - A vsync_pulse or force_commit while CLEAN does nothing: no copy, no commit_ack.
//  - IMMEDIATE=1:
//    - A write hit updates shadow[idx] and active[idx] at the same edge.
//    - pending is tied 0; vsync_pulse and force_commit are ignored; commit_ack is tied 0.
//  - active_regs changes only on a commit edge or a reset edge (or a write edge when IMMEDIATE=1).
// TESTING
//  1 Reset; read idx 0,5,31,32,255 -> rd_data 01,06,20,00,00; rd_valid one cycle after each re.
//  2 Write idx 3=AA, no vsync -> read-back AA, active[3]=04, pending=1.
//    Then pulse vsync -> active[3]=AA, commit_ack 1 cycle, pending=0.
//  3 Write addr 20'h00105 (upper bits mismatch) -> shadow unchanged, pending=0, rd_valid never set.
//  4 Write idx 7=55 in the vsync cycle (state DIRTY) -> active[7]=55.
//    Write idx 8=66 during COMMIT -> active[8]=09, pending stays 1; next vsync -> active[8]=66.
//  5 Same-cycle re+we on idx 2 (data 77) -> rd_data=03; next read -> 77.
//  6 Assert rst mid-DIRTY -> pending=0, shadow[3] and active[3] back to 04.
//    With IMMEDIATE=1: write idx 1=C3 -> active[1]=C3 on the next edge, no vsync needed.

Source files
------------

// File: rtl/gpu_hw_regs_shadowed.sv
// Double-buffered GPU control register bank: host writes go to a shadow bank that is
// copied in one cycle into the active bank at a frame boundary (or tracks it when IMMEDIATE=1).
module gpu_hw_regs_shadowed #(
  parameter int                ADDR_W    = 20,
  parameter int                REG_AW    = 8,
  parameter int                DW        = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                RST_COUNT = 32,
  parameter bit                IMMEDIATE = 1'b0,
  localparam int               NUM_REGS  = 2**REG_AW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic                           re,
  input  logic [ADDR_W-1:0]              addr_in,
  input  logic [DW-1:0]                  data_in,
  output logic [DW-1:0]                  rd_data,
  output logic                           rd_valid,
  input  logic                           vsync_pulse,
  input  logic                           force_commit,
  output logic                           pending,
  output logic                           commit_ack,
  output logic [0:NUM_REGS-1][DW-1:0]    active_regs
);

  typedef logic [0:NUM_REGS-1][DW-1:0] bank_t;
  typedef enum logic [1:0] {S_CLEAN, S_DIRTY, S_COMMIT} state_t;

  function automatic bank_t rst_bank();
    bank_t b;
    for (int i = 0; i < NUM_REGS; i++)
      b[i] = (i < RST_COUNT) ? DW'(i + 1) : '0;
    return b;
  endfunction

  bank_t             shadow_q, shadow_d;
  bank_t             active_q, active_d;
  state_t            state_q, state_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              commit_ack_q, commit_ack_d;
  logic              hit, wr_hit, rd_hit;
  logic [REG_AW-1:0] idx;

  always_comb begin
    hit    = addr_in[ADDR_W-1:REG_AW] == BASE_ADDR[ADDR_W-1:REG_AW];
    idx    = addr_in[REG_AW-1:0];
    wr_hit = we && hit;
    rd_hit = re && hit;

    shadow_d = shadow_q;
    if (wr_hit) shadow_d[idx] = data_in;

    // Read samples the pre-write shadow so a same-cycle write is not visible yet.
    rd_data_d  = rd_hit ? shadow_q[idx] : rd_data_q;
    rd_valid_d = rd_hit;

    active_d     = active_q;
    state_d      = state_q;
    commit_ack_d = 1'b0;
    if (IMMEDIATE) begin
      state_d = S_CLEAN;
      if (wr_hit) active_d[idx] = data_in;
    end else begin
      case (state_q)
        S_CLEAN:  if (wr_hit) state_d = S_DIRTY;
        S_DIRTY:  if (vsync_pulse || force_commit) state_d = S_COMMIT;
        S_COMMIT: begin
          // Copy uses shadow_q, so a write landing now stays uncommitted.
          active_d     = shadow_q;
          commit_ack_d = 1'b1;
          state_d      = wr_hit ? S_DIRTY : S_CLEAN;
        end
        default:  state_d = S_CLEAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q     <= rst_bank();
      active_q     <= rst_bank();
      state_q      <= S_CLEAN;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      commit_ack_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      state_q      <= state_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      commit_ack_q <= commit_ack_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign commit_ack  = commit_ack_q;
  assign pending     = !IMMEDIATE && (state_q != S_CLEAN);
  assign active_regs = active_q;

endmodule
